// File: rtl/i2s_tx_param.sv
// I2S master transmitter with programmable SCK divider, Philips/LJ framing,
// mono duplication and a one-deep valid/ready holding register.
//
// Ports:
//   i_clk, i_nrst          system clock, async active-low reset
//   i_enable               transmitter run (0 clears serial state)
//   i_clk_div              SCK half-period = i_clk_div+1 i_clk cycles
//   i_mode                 0 = Philips I2S, 1 = left-justified
//   i_mono                 1 = left sample sent in both slots
//   i_valid, o_ready       sample-pair handshake into the holding register
//   i_data_left/right      sample pair, MSB-first
//   o_underrun             sticky: a frame started with no sample held
//   i_underrun_clr         clears o_underrun
//   o_frame_start          one-cycle pulse after each frame load
//   o_sck, o_ws, o_sd      I2S serial bus
module i2s_tx_param #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int CLKDIV_W = 8
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_enable,
    input  logic [CLKDIV_W-1:0] i_clk_div,
    input  logic                i_mode,
    input  logic                i_mono,
    input  logic                i_valid,
    input  logic [DATA_W-1:0]   i_data_left,
    input  logic [DATA_W-1:0]   i_data_right,
    output logic                o_ready,
    output logic                o_underrun,
    input  logic                i_underrun_clr,
    output logic                o_frame_start,
    output logic                o_sck,
    output logic                o_ws,
    output logic                o_sd
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int POS_W   = $clog2(FRAME_W);

    logic                en_q;
    logic [CLKDIV_W-1:0] div_r;
    logic [CLKDIV_W-1:0] div_cnt;
    logic [CLKDIV_W-1:0] div_eff;
    logic                sck_r;
    logic [POS_W-1:0]    pos;
    logic                ws_r;
    logic [FRAME_W-1:0]  shift_r;
    logic                dly_r;
    logic                mode_r;
    logic                underrun_r;
    logic                fs_r;

    logic                full;
    logic [DATA_W-1:0]   hold_l;
    logic [DATA_W-1:0]   hold_r;

    logic                wrap;
    logic                tick;
    logic                load;
    logic                accept;
    logic [DATA_W-1:0]   r_sel;
    logic [FRAME_W-1:0]  frame_word;

    // On the first enabled cycle the divider value is taken straight from
    // the port, so the latched copy is not needed yet.
    assign div_eff = en_q ? div_r : i_clk_div;
    assign wrap    = i_enable && (div_cnt == div_eff);
    // A wrap while SCK is high is the falling edge: the only point where
    // WS and SD may change.
    assign tick    = wrap && sck_r;
    // pos holds the position that the next tick will present.
    assign load    = tick && (pos == '0);
    assign accept  = i_valid && !full;

    assign r_sel      = i_mono ? hold_l : hold_r;
    assign frame_word = (FRAME_W'(hold_l) << (FRAME_W - DATA_W))
                      | (FRAME_W'(r_sel) << (SLOT_W - DATA_W));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            en_q       <= 1'b0;
            div_r      <= '0;
            div_cnt    <= '0;
            sck_r      <= 1'b0;
            pos        <= '0;
            ws_r       <= 1'b0;
            shift_r    <= '0;
            dly_r      <= 1'b0;
            mode_r     <= 1'b0;
            underrun_r <= 1'b0;
            fs_r       <= 1'b0;
        end else if (!i_enable) begin
            en_q       <= 1'b0;
            div_cnt    <= '0;
            sck_r      <= 1'b0;
            pos        <= '0;
            ws_r       <= 1'b0;
            shift_r    <= '0;
            dly_r      <= 1'b0;
            underrun_r <= 1'b0;
            fs_r       <= 1'b0;
        end else begin
            en_q <= 1'b1;
            if (!en_q) begin
                div_r <= i_clk_div;
            end
            if (wrap) begin
                div_cnt <= '0;
                sck_r   <= ~sck_r;
            end else begin
                div_cnt <= div_cnt + CLKDIV_W'(1);
            end
            fs_r <= load;
            if (tick) begin
                // Philips mode shows the bit the previous tick presented.
                dly_r <= shift_r[FRAME_W-1];
                ws_r  <= (pos >= POS_W'(SLOT_W));
                if (pos == POS_W'(FRAME_W - 1)) begin
                    pos <= '0;
                end else begin
                    pos <= pos + POS_W'(1);
                end
                if (load) begin
                    mode_r  <= i_mode;
                    shift_r <= full ? frame_word : '0;
                end else begin
                    shift_r <= shift_r << 1;
                end
            end
            if (load && !full) begin
                underrun_r <= 1'b1;
            end else if (i_underrun_clr) begin
                underrun_r <= 1'b0;
            end
        end
    end

    // Holding register keeps running while disabled so a sample can be
    // queued before the transmitter starts.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            full   <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
        end else begin
            if (load) begin
                // Full: drained into the frame. Empty: an accept in the
                // same cycle is kept for the following frame.
                full <= accept;
            end else if (accept) begin
                full <= 1'b1;
            end
            if (accept) begin
                hold_l <= i_data_left;
                hold_r <= i_data_right;
            end
        end
    end

    assign o_ready       = ~full;
    assign o_underrun    = underrun_r;
    assign o_frame_start = fs_r;
    assign o_sck         = i_enable & sck_r;
    assign o_ws          = i_enable & ws_r;
    assign o_sd          = i_enable & (mode_r ? shift_r[FRAME_W-1] : dly_r);

endmodule
